// File: rtl/flag_cond_reader.sv
// Branch/jump condition evaluator on the processor flag register.
// Evaluation waits until no flag write is outstanding, so it never reads stale flags.
module flag_cond_reader #(
   parameter int PEND_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        i_flags_in,
   input  logic              i_flag_wr_issue,
   input  logic              i_flag_wr_retire,
   input  logic              i_req_valid,
   input  logic [3:0]        i_req_cond,
   output logic              o_req_ready,
   output logic              o_resp_valid,
   output logic              o_resp_taken,
   input  logic              i_resp_ack,
   output logic [PEND_W-1:0] o_pending_count,
   output logic              o_err
);

   // state  | meaning
   // IDLE   | ready for a request
   // WAIT   | request latched, waiting for in-flight flag writes to drain
   // RESP   | result held until acknowledged
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

   logic [1:0]        r_state;
   logic [3:0]        r_cond;
   logic              r_taken;
   logic [PEND_W-1:0] r_pend;
   logic              r_err;

   logic w_inc;
   logic w_dec;
   logic w_eval_ok;
   logic w_cond_true;
   logic w_flag_n, w_flag_z, w_flag_f, w_flag_l, w_flag_c;

   assign {w_flag_n, w_flag_z, w_flag_f, w_flag_l, w_flag_c} = i_flags_in;

   assign w_inc     = i_flag_wr_issue & ~i_flag_wr_retire;
   assign w_dec     = i_flag_wr_retire & ~i_flag_wr_issue;
   // an issue this cycle precedes the branch in program order, so it blocks evaluation
   assign w_eval_ok = (r_pend == '0) & ~i_flag_wr_issue;

   always_comb begin
      w_cond_true = 1'b0;
      case (r_cond)
         4'b0000: w_cond_true = w_flag_z;
         4'b0001: w_cond_true = ~w_flag_z;
         4'b0010: w_cond_true = w_flag_c;
         4'b0011: w_cond_true = ~w_flag_c;
         4'b0100: w_cond_true = w_flag_l;
         4'b0101: w_cond_true = ~w_flag_l;
         4'b0110: w_cond_true = w_flag_n;
         4'b0111: w_cond_true = ~w_flag_n;
         4'b1000: w_cond_true = w_flag_f;
         4'b1001: w_cond_true = ~w_flag_f;
         4'b1010: w_cond_true = ~w_flag_l & ~w_flag_z;
         4'b1011: w_cond_true = w_flag_l | w_flag_z;
         4'b1100: w_cond_true = ~w_flag_n & ~w_flag_z;
         4'b1101: w_cond_true = w_flag_n | w_flag_z;
         4'b1110: w_cond_true = 1'b1;
         default: w_cond_true = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend <= '0;
         r_err  <= 1'b0;
      end else if (w_inc) begin
         if (r_pend == PEND_MAX) r_err  <= 1'b1;
         else                    r_pend <= r_pend + 1'b1;
      end else if (w_dec) begin
         if (r_pend == '0) r_err  <= 1'b1;
         else              r_pend <= r_pend - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cond  <= 4'b0000;
         r_taken <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_cond <= i_req_cond;
                  // always/never codes have no flag dependency
                  if (i_req_cond[3:1] == 3'b111) begin
                     r_taken <= ~i_req_cond[0];
                     r_state <= S_RESP;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (w_eval_ok) begin
                  r_taken <= w_cond_true;
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               if (i_resp_ack) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_req_ready     = (r_state == S_IDLE);
   assign o_resp_valid    = (r_state == S_RESP);
   assign o_resp_taken    = r_taken;
   assign o_pending_count = r_pend;
   assign o_err           = r_err;

endmodule

// File: tb/tb_flag_cond_reader.sv
// Self-checking bench for flag_cond_reader: scoreboard of expected branch outcomes.
module tb_flag_cond_reader;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] flags_in;
   logic       flag_wr_issue, flag_wr_retire;
   logic       req_valid;
   logic [3:0] req_cond;
   logic       req_ready, resp_valid, resp_taken, resp_ack;
   logic [2:0] pending_count;
   logic       err;

   int checks = 0;
   int errors = 0;
   logic exp_q[$];

   flag_cond_reader #(.PEND_W(3)) dut (
      .clk             (clk),
      .reset           (reset),
      .i_flags_in      (flags_in),
      .i_flag_wr_issue (flag_wr_issue),
      .i_flag_wr_retire(flag_wr_retire),
      .i_req_valid     (req_valid),
      .i_req_cond      (req_cond),
      .o_req_ready     (req_ready),
      .o_resp_valid    (resp_valid),
      .o_resp_taken    (resp_taken),
      .i_resp_ack      (resp_ack),
      .o_pending_count (pending_count),
      .o_err           (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic model(input logic [3:0] c, input logic [4:0] f);
      logic n, z, ff, l, cy;
      n = f[4]; z = f[3]; ff = f[2]; l = f[1]; cy = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return l;
         4'd5:  return !l;
         4'd6:  return n;
         4'd7:  return !n;
         4'd8:  return ff;
         4'd9:  return !ff;
         4'd10: return !l && !z;
         4'd11: return l || z;
         4'd12: return !n && !z;
         4'd13: return n || z;
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Waits for resp_valid, returns edges counted from the accept edge.
   task automatic wait_resp(output int lat, output logic got);
      lat = 1;
      got = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1'b1;
            break;
         end
         tick();
         lat++;
      end
   endtask

   task automatic pop_check(input string tag);
      logic e;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 8'd1, 8'd0);
      end else begin
         e = exp_q.pop_front();
         chk(tag, {7'd0, resp_taken}, {7'd0, e});
      end
   endtask

   task automatic do_ack();
      resp_ack = 1'b1;
      tick();
      resp_ack = 1'b0;
      @(negedge clk);
      chk("ack_ready", {7'd0, req_ready}, 8'd1);
      chk("ack_valid", {7'd0, resp_valid}, 8'd0);
      #1;
   endtask

   // Full request with pending=0; checks latency and outcome.
   task automatic do_req(input logic [3:0] c, input bit verbose);
      int   lat;
      logic got;
      if (verbose) chk("pre_ready", {7'd0, req_ready}, 8'd1);
      exp_q.push_back(model(c, flags_in));
      req_valid = 1'b1;
      req_cond  = c;
      tick();
      req_valid = 1'b0;
      wait_resp(lat, got);
      chk("resp_timeout", {7'd0, got}, 8'd1);
      chk("latency", lat[7:0], (c >= 4'd14) ? 8'd1 : 8'd2);
      pop_check("taken");
      #1;
      do_ack();
   endtask

   initial begin
      int   lat;
      logic got;
      reset = 1'b1; flags_in = 5'b0; flag_wr_issue = 0; flag_wr_retire = 0;
      req_valid = 0; req_cond = 4'b0; resp_ack = 0;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", {7'd0, req_ready}, 8'd1);
      chk("rst_valid", {7'd0, resp_valid}, 8'd0);
      chk("rst_taken", {7'd0, resp_taken}, 8'd0);
      chk("rst_pend", {5'd0, pending_count}, 8'd0);
      chk("rst_err", {7'd0, err}, 8'd0);
      #1;

      // Basic EQ with Z=1
      flags_in = 5'b01000;
      do_req(4'b0000, 1'b1);

      // Stale-flag protection
      flag_wr_issue = 1; tick(); tick(); flag_wr_issue = 0;
      @(negedge clk); chk("pend2", {5'd0, pending_count}, 8'd2); #1;
      flags_in = 5'b00000;
      exp_q.push_back(1'b1);
      req_valid = 1; req_cond = 4'b0010; tick(); req_valid = 0;
      tick(); tick();
      @(negedge clk); chk("wait_hold", {7'd0, resp_valid}, 8'd0); #1;
      flag_wr_retire = 1; flags_in = 5'b00001; tick(); flag_wr_retire = 0;
      tick();
      flag_wr_retire = 1; tick(); flag_wr_retire = 0;
      @(negedge clk);
      chk("wait_pend0", {7'd0, resp_valid}, 8'd0);
      chk("pend0", {5'd0, pending_count}, 8'd0);
      #1;
      tick();
      @(negedge clk);
      chk("stale_valid", {7'd0, resp_valid}, 8'd1);
      pop_check("stale_taken");
      #1;
      do_ack();

      // Same-cycle issue blocks evaluation
      exp_q.push_back(1'b0);
      flags_in = 5'b00000;
      req_valid = 1; req_cond = 4'b0000; tick(); req_valid = 0;
      flag_wr_issue = 1; flag_wr_retire = 1;
      tick(); tick();
      @(negedge clk); chk("issue_block", {7'd0, resp_valid}, 8'd0); #1;
      flag_wr_issue = 0; flag_wr_retire = 0;
      wait_resp(lat, got);
      chk("issue_block_to", {7'd0, got}, 8'd1);
      pop_check("issue_block_taken");
      #1;
      do_ack();

      // Exhaustive condition sweep
      for (int f = 0; f < 32; f++) begin
         flags_in = f[4:0];
         for (int c = 0; c < 16; c++) do_req(c[3:0], 1'b0);
      end

      // Counter: simultaneous, saturation, underflow
      chk("sim_pend", {5'd0, pending_count}, 8'd0);
      chk("sim_err", {7'd0, err}, 8'd0);
      repeat (8) begin flag_wr_issue = 1; tick(); end
      flag_wr_issue = 0;
      @(negedge clk);
      chk("sat_pend", {5'd0, pending_count}, 8'd7);
      chk("sat_err", {7'd0, err}, 8'd1);
      #1;
      repeat (8) begin flag_wr_retire = 1; tick(); end
      flag_wr_retire = 0;
      @(negedge clk);
      chk("under_pend", {5'd0, pending_count}, 8'd0);
      chk("under_err", {7'd0, err}, 8'd1);
      #1;

      // Reset during WAIT
      flag_wr_issue = 1; tick(); flag_wr_issue = 0;
      req_valid = 1; req_cond = 4'b0001; tick(); req_valid = 0;
      tick();
      @(negedge clk); chk("in_wait", {7'd0, req_ready}, 8'd0); #1;
      reset = 1; tick(); reset = 0;
      @(negedge clk);
      chk("mid_rst_ready", {7'd0, req_ready}, 8'd1);
      chk("mid_rst_valid", {7'd0, resp_valid}, 8'd0);
      chk("mid_rst_pend", {5'd0, pending_count}, 8'd0);
      chk("mid_rst_err", {7'd0, err}, 8'd0);
      #1;
      repeat (4) begin
         tick();
         @(negedge clk); chk("no_spurious", {7'd0, resp_valid}, 8'd0); #1;
      end

      // Hold in RESP while flags toggle and req_valid stays high
      flags_in = 5'b01000;
      exp_q.push_back(1'b1);
      req_valid = 1; req_cond = 4'b0000; tick();
      wait_resp(lat, got);
      chk("hold_to", {7'd0, got}, 8'd1);
      chk("hold_lat", lat[7:0], 8'd2);
      pop_check("hold_taken");
      #1;
      for (int i = 0; i < 10; i++) begin
         flags_in = 5'(i * 7 + 1) & 5'b10111;
         tick();
         @(negedge clk);
         chk("hold_valid", {7'd0, resp_valid}, 8'd1);
         chk("hold_tkn", {7'd0, resp_taken}, 8'd1);
         chk("hold_noaccept", {7'd0, req_ready}, 8'd0);
         #1;
      end
      req_valid = 0;
      do_ack();

      chk("queue_drained", 8'(exp_q.size()), 8'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
